// File: rtl/minion_uart_pkg.sv
// Shared definitions for the minion UART blocks.
//   rx_state_e    : receiver FSM states
//   MIN_DIV       : smallest usable baud divisor (smaller requests are clamped)
//   DEFAULT_DIV_W : default width of the baud divisor
package minion_uart_pkg;

  localparam int MIN_DIV       = 4;
  localparam int DEFAULT_DIV_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/minion_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : write wdata_i (accepted when not full, or when full and popping)
//   wdata_i    : write data
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry, valid whenever empty_o is 0
//   empty_o    : no entries
//   full_o     : DEPTH entries
//   count_o    : current number of entries
module minion_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/minion_uart_rx.sv
// 8N1 UART receiver with oversampling bit timer and FWFT receive FIFO.
//   msoc_clk   : clock
//   rst        : synchronous active-high reset
//   baud_div   : clocks per bit (values below MIN_DIV are clamped)
//   rx         : asynchronous serial line, idle high
//   rx_data    : FIFO head, 0x00 when empty
//   rx_valid   : FIFO not empty
//   rx_ready   : pop head when rx_valid && rx_ready
//   frame_err  : 1-cycle pulse on bad stop bit with non-zero data
//   overrun    : 1-cycle pulse when a good byte is dropped on a full FIFO
//   u_break    : high while the line break is held
//   fifo_count : FIFO occupancy
module minion_uart_rx
  import minion_uart_pkg::*;
#(
  parameter int DIV_W      = DEFAULT_DIV_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        msoc_clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        u_break,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q;
  logic             rxs, rxs_prev_q;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             fe_q, fe_d, ov_q, ov_d;
  logic             push, tick;
  logic             fifo_empty, fifo_full, pop_fire;
  logic [7:0]       fifo_rdata;

  assign rxs      = sync_q[1];
  assign tick     = (cnt_q == '0);
  assign div_eff  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign pop_fire = rx_ready && !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    div_d   = div_q;
    push    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rxs_prev_q && !rxs) begin
          // Divisor is frozen for the whole frame; first sample is mid start bit.
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = tick ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
        if (tick) begin
          if (!rxs) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        cnt_d = tick ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
        if (tick) begin
          data_d = {rxs, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = tick ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
        if (tick) begin
          if (rxs) begin
            // A pop in the same cycle frees a slot even when full.
            if (!fifo_full || pop_fire) push = 1'b1;
            else                        ov_d = 1'b1;
            state_d = ST_IDLE;
          end else if (data_q == 8'h00) begin
            state_d = ST_BREAK;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE, ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rxs_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      div_q      <= DIV_W'(MIN_DIV);
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      rxs_prev_q <= rxs;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      div_q      <= div_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  minion_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (msoc_clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (data_q),
    .pop_i   (rx_ready),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign rx_valid  = !fifo_empty;
  assign rx_data   = rx_valid ? fifo_rdata : 8'h00;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign u_break   = (state_q == ST_BREAK);

endmodule

// File: tb/tb_minion_uart_rx.sv
module tb_minion_uart_rx;

  logic        msoc_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd8;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err, overrun, u_break;
  logic [4:0]  fifo_count;

  minion_uart_rx #(.DIV_W(16), .FIFO_DEPTH(16)) dut (
    .msoc_clk   (msoc_clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .u_break    (u_break),
    .fifo_count (fifo_count)
  );

  always #5 msoc_clk = ~msoc_clk;

  int         nchk = 0;
  int         nerr = 0;
  int         eff = 8;
  int         fe_cyc = 0, ov_cyc = 0, brk_rise = 0;
  logic       ub_prev = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  // Consumer side: everything handed over on a valid&&ready cycle is recorded.
  always @(negedge msoc_clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (frame_err) fe_cyc++;
      if (overrun) ov_cyc++;
      if (u_break && !ub_prev) brk_rise++;
    end
    ub_prev = u_break;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge msoc_clk);
    #1;
  endtask

  // Drive one 8N1 frame at the effective divisor; line idles high afterwards.
  task automatic send(input logic [7:0] d, input logic sb);
    rx = 1'b0; cyc(eff);
    for (int i = 0; i < 8; i++) begin rx = d[i]; cyc(eff); end
    rx = sb; cyc(eff);
    rx = 1'b1;
  endtask

  task automatic chk_got(input string tag);
    chk({tag, "_n"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, {24'h0, got[i]}, {24'h0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int ov0, fe0, b0;
    logic [7:0] d;

    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_brk", u_break, 0);
    chk("rst_cnt", fifo_count, 0);
    cyc(5);

    // Back-to-back frames, consumer always ready.
    rx_ready = 1'b1;
    send(8'h55, 1'b1); exp_q.push_back(8'h55);
    send(8'hA3, 1'b1); exp_q.push_back(8'hA3);
    cyc(20);
    chk_got("b2b");
    chk("b2b_flags", fe_cyc + ov_cyc + brk_rise, 0);

    // Fill to capacity, one more byte overruns.
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i);
      send(d, 1'b1);
      exp_q.push_back(d);
    end
    cyc(4);
    chk("full_cnt", fifo_count, 16);
    chk("ov_before", ov_cyc, 0);
    send(8'h10, 1'b1);
    cyc(4);
    chk("ov_once", ov_cyc, 1);
    chk("full_cnt2", fifo_count, 16);
    rx_ready = 1'b1;
    cyc(24);
    chk_got("drain");
    chk("drain_cnt", fifo_count, 0);
    chk("empty_data", rx_data, 0);
    chk("empty_valid", rx_valid, 0);

    // Line break for 12 bit times.
    ov0 = ov_cyc; fe0 = fe_cyc;
    rx = 1'b0;
    cyc(12 * eff);
    chk("brk_hi", u_break, 1);
    chk("brk_rise", brk_rise, 1);
    chk("brk_cnt", fifo_count, 0);
    rx = 1'b1;
    cyc(3);
    chk("brk_lo", u_break, 0);
    cyc(10);
    chk("brk_nopush", got.size(), 0);
    chk("brk_noflag", (ov_cyc - ov0) + (fe_cyc - fe0), 0);

    // Bad stop bit on non-zero data.
    b0 = brk_rise; fe0 = fe_cyc;
    send(8'hA5, 1'b0);
    cyc(16);
    chk("fe_pulse", fe_cyc - fe0, 1);
    chk("fe_nobrk", brk_rise - b0, 0);
    chk("fe_cnt", fifo_count, 0);
    chk("fe_nopush", got.size(), 0);
    send(8'h3C, 1'b1); exp_q.push_back(8'h3C);
    cyc(16);
    chk_got("after_fe");

    // Short glitch at a slow rate.
    baud_div = 16'd16; eff = 16;
    fe0 = fe_cyc; ov0 = ov_cyc; b0 = brk_rise;
    rx = 1'b0; cyc(2); rx = 1'b1;
    cyc(24);
    chk("gl_nopush", got.size(), 0);
    chk("gl_noflag", (fe_cyc - fe0) + (ov_cyc - ov0) + (brk_rise - b0), 0);
    send(8'h81, 1'b1); exp_q.push_back(8'h81);
    cyc(24);
    chk_got("after_gl");

    // Reset in the middle of data bit 4 with one byte queued.
    baud_div = 16'd8; eff = 8;
    rx_ready = 1'b0;
    send(8'h11, 1'b1);
    cyc(6);
    chk("pre_rst_cnt", fifo_count, 1);
    d = 8'hC3;
    rx = 1'b0; cyc(eff);
    for (int i = 0; i < 4; i++) begin rx = d[i]; cyc(eff); end
    rx = d[4]; cyc(eff / 2);
    rst = 1'b1; rx = 1'b1;
    cyc(1);
    chk("mr_valid", rx_valid, 0);
    chk("mr_data", rx_data, 0);
    chk("mr_cnt", fifo_count, 0);
    chk("mr_flags", {frame_err, overrun, u_break}, 0);
    cyc(2);
    rst = 1'b0;
    cyc(eff * 12);
    chk("post_rst_cnt", fifo_count, 0);
    rx_ready = 1'b1;
    send(8'h7E, 1'b1); exp_q.push_back(8'h7E);
    cyc(16);
    chk_got("after_rst");

    // Random bytes at random divisors, including values that get clamped.
    for (int r = 0; r < 3; r++) begin
      baud_div = 16'($urandom_range(0, 12));
      eff = (baud_div < 16'd4) ? 4 : int'(baud_div);
      cyc(4);
      for (int i = 0; i < 6; i++) begin
        d = 8'($urandom);
        send(d, 1'b1);
        exp_q.push_back(d);
      end
      cyc(3 * eff + 8);
      chk_got("rand");
    end
    chk("rand_noflag", fe_cyc - fe0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
